// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - opcode enumerations, OP_* encodings and stage 1 payload for alu_pipe
package alu_pipe_pkg;

    localparam int MAX_WIDTH = 64;
    localparam int MAX_SHW   = 6;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDC = 3'b010;
    localparam logic [2:0] OP_SUBB = 3'b011;
    localparam logic [2:0] OP_SADD = 3'b100;
    localparam logic [2:0] OP_SSUB = 3'b101;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;

    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;

    typedef enum logic [2:0] {
        SEL_ARITH = 3'b001,
        SEL_LOGIC = 3'b010,
        SEL_SHIFT = 3'b011
    } opsel_e;

    typedef enum logic [2:0] {
        A_ADD  = OP_ADD,
        A_SUB  = OP_SUB,
        A_ADDC = OP_ADDC,
        A_SUBB = OP_SUBB,
        A_SADD = OP_SADD,
        A_SSUB = OP_SSUB
    } arith_op_e;

    typedef enum logic [2:0] {
        L_AND = OP_AND,
        L_OR  = OP_OR,
        L_XOR = OP_XOR,
        L_NOT = OP_NOT
    } logic_op_e;

    typedef enum logic [2:0] {
        S_SLL = OP_SLL,
        S_SRL = OP_SRL,
        S_SRA = OP_SRA,
        S_ROL = OP_ROL,
        S_ROR = OP_ROR
    } shift_op_e;

    // Sized for the widest supported WIDTH; the top only fills the low bits.
    typedef struct packed {
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
        logic [2:0]           opsel;
        logic [2:0]           op;
        logic [MAX_SHW-1:0]   shamt;
    } s1_payload_t;

endpackage

// File: rtl/alu_pipe_shifter.sv
// rtl/alu_pipe_shifter.sv - combinational barrel shifter/rotator returning result and last bit out
module alu_pipe_shifter
    import alu_pipe_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   shamt,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             last_out
);

    logic [2*WIDTH-1:0] wl;
    logic [2*WIDTH-1:0] wr;
    logic [WIDTH-1:0]   sra;

    // Double-width shifts: bits pushed past the edge land in the other half,
    // so the last bit out sits next to the boundary and is 0 for a zero amount.
    assign wl  = {{WIDTH{1'b0}}, data} << shamt;
    assign wr  = {data, {WIDTH{1'b0}}} >> shamt;
    assign sra = $signed(data) >>> shamt;

    always_comb begin
        result   = data;
        last_out = 1'b0;
        case (shift_op_e'(op))
            S_SLL: begin
                result   = wl[WIDTH-1:0];
                last_out = wl[WIDTH];
            end
            S_SRL: begin
                result   = wr[2*WIDTH-1:WIDTH];
                last_out = wr[WIDTH-1];
            end
            S_SRA: begin
                result   = sra;
                last_out = wr[WIDTH-1];
            end
            S_ROL: begin
                result   = wl[WIDTH-1:0] | wl[2*WIDTH-1:WIDTH];
                last_out = wl[WIDTH];
            end
            S_ROR: begin
                result   = wr[2*WIDTH-1:WIDTH] | wr[WIDTH-1:0];
                last_out = wr[WIDTH-1];
            end
            default: begin
                result   = data;
                last_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined ALU with valid/ready handshake and carry chain
// Optional saturating SADD/SSUB under `ALU_PIPE_SAT_EN.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] aluin1,
    input  logic [WIDTH-1:0] aluin2,
    input  logic [2:0]       opselect,
    input  logic [2:0]       operation,
    input  logic [SHW-1:0]   shift_number,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluout,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             v1;
    logic             adv1;
    logic             adv2;
    logic             carry_flag;
    s1_payload_t      s1_q;
    s1_payload_t      s1_d;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_d;
    logic             c_d;
    logic             v_d;
    logic             ill_d;
    logic             flag_we;
    logic [WIDTH-1:0] shf_res;
    logic             shf_last;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    always_comb begin
        s1_d                  = '0;
        s1_d.a[WIDTH-1:0]     = aluin1;
        s1_d.b[WIDTH-1:0]     = aluin2;
        s1_d.opsel            = opselect;
        s1_d.op               = operation;
        s1_d.shamt[SHW-1:0]   = shift_number;
    end

    if (WIDTH < MAX_WIDTH) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^{s1_q.a[MAX_WIDTH-1:WIDTH], s1_q.b[MAX_WIDTH-1:WIDTH],
                              s1_q.shamt[MAX_SHW-1:SHW]};
    end

    assign a = s1_q.a[WIDTH-1:0];
    assign b = s1_q.b[WIDTH-1:0];

    alu_pipe_shifter #(.WIDTH(WIDTH)) u_shifter (
        .data     (a),
        .shamt    (s1_q.shamt[SHW-1:0]),
        .op       (s1_q.op),
        .result   (shf_res),
        .last_out (shf_last)
    );

    always_comb begin
        sum     = '0;
        res_d   = '0;
        c_d     = 1'b0;
        v_d     = 1'b0;
        ill_d   = 1'b0;
        flag_we = 1'b0;
        case (opsel_e'(s1_q.opsel))
            SEL_ARITH: begin
                case (arith_op_e'(s1_q.op))
                    A_ADD, A_ADDC: begin
                        sum = {1'b0, a} + {1'b0, b}
                            + {{WIDTH{1'b0}}, (s1_q.op == OP_ADDC) & carry_flag};
                        res_d   = sum[WIDTH-1:0];
                        c_d     = sum[WIDTH];
                        v_d     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                        flag_we = 1'b1;
                    end
                    A_SUB, A_SUBB: begin
                        // Bit WIDTH of the widened difference is the unsigned borrow.
                        sum = {1'b0, a} - {1'b0, b}
                            - {{WIDTH{1'b0}}, (s1_q.op == OP_SUBB) & carry_flag};
                        res_d   = sum[WIDTH-1:0];
                        c_d     = sum[WIDTH];
                        v_d     = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                        flag_we = 1'b1;
                    end
`ifdef ALU_PIPE_SAT_EN
                    A_SADD, A_SSUB: begin
                        if (s1_q.op == OP_SADD) begin
                            sum = {1'b0, a} + {1'b0, b};
                            v_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                        end else begin
                            sum = {1'b0, a} - {1'b0, b};
                            v_d = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                        end
                        // On overflow the true result has the sign of aluin1.
                        res_d = v_d ? (a[WIDTH-1] ? SMIN : SMAX) : sum[WIDTH-1:0];
                    end
`endif
                    default: ill_d = 1'b1;
                endcase
            end
            SEL_LOGIC: begin
                case (logic_op_e'(s1_q.op))
                    L_AND:   res_d = a & b;
                    L_OR:    res_d = a | b;
                    L_XOR:   res_d = a ^ b;
                    L_NOT:   res_d = ~a;
                    default: ill_d = 1'b1;
                endcase
            end
            SEL_SHIFT: begin
                if (s1_q.op <= OP_ROR) begin
                    res_d = shf_res;
                    c_d   = shf_last;
                end else begin
                    ill_d = 1'b1;
                end
            end
            default: ill_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            v1         <= 1'b0;
            out_valid  <= 1'b0;
            carry_flag <= 1'b0;
            s1_q       <= '0;
            aluout     <= '0;
            carryout   <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b1;
            illegal    <= 1'b0;
        end else begin
            if (adv2) begin
                out_valid <= v1;
                if (v1) begin
                    aluout   <= res_d;
                    carryout <= c_d;
                    overflow <= v_d;
                    zero     <= (res_d == '0);
                    illegal  <= ill_d;
                    if (flag_we) begin
                        carry_flag <= c_d;
                    end
                end
            end
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe with directed hand-computed vectors
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] aluin1;
    logic [31:0] aluin2;
    logic [2:0]  opselect;
    logic [2:0]  operation;
    logic [4:0]  shift_number;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluout;
    logic        carryout;
    logic        overflow;
    logic        zero;
    logic        illegal;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .aluin1       (aluin1),
        .aluin2       (aluin2),
        .opselect     (opselect),
        .operation    (operation),
        .shift_number (shift_number),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .aluout       (aluout),
        .carryout     (carryout),
        .overflow     (overflow),
        .zero         (zero),
        .illegal      (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        #2;
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h required none", aluout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {28'd0, aluout, carryout, overflow, zero, illegal}, {28'd0, e});
            end
        end
    end

    task automatic issue(input logic [2:0] sel, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input logic [31:0] r, input logic c, input logic v,
                         input logic z, input logic ill);
        int  tries = 0;
        bit  done  = 0;
        while (!done) begin
            @(negedge clock);
            in_valid     = 1'b1;
            opselect     = sel;
            operation    = op;
            aluin1       = a;
            aluin2       = b;
            shift_number = sh;
            #1;
            if (in_ready) begin
                sb.push_back({r, c, v, z, ill});
                done = 1;
            end else if (++tries > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL issue_timeout: got in_ready 0 required 1");
                done = 1;
            end
        end
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int tries = 0;
        while (sb.size() != 0 && tries < 50) begin
            @(negedge clock);
            tries++;
        end
        #3;
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        aluin1       = '0;
        aluin2       = '0;
        opselect     = '0;
        operation    = '0;
        shift_number = '0;
        repeat (3) @(negedge clock);
        #1;
        check("reset_outputs", {out_valid, aluout, carryout, overflow, zero, illegal},
              {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Arithmetic and carry chain
        issue(SEL_ARITH, OP_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 0, 1, 0, 0);
        issue(SEL_ARITH, OP_SUB,  32'd5,        32'd7,        5'd0, 32'hFFFFFFFE, 1, 0, 0, 0);
        issue(SEL_ARITH, OP_SUBB, 32'd0,        32'd0,        5'd0, 32'hFFFFFFFF, 1, 0, 0, 0);
        issue(SEL_ARITH, OP_ADDC, 32'd0,        32'd0,        5'd0, 32'h00000001, 0, 0, 0, 0);
        // Logic
        issue(SEL_LOGIC, OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 0, 0, 0, 0);
        issue(SEL_LOGIC, OP_XOR,  32'hA5A5A5A5, 32'hA5A5A5A5, 5'd0, 32'h00000000, 0, 0, 1, 0);
        issue(SEL_LOGIC, OP_NOT,  32'h00000000, 32'h12345678, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0);
        // Shifts and rotates
        issue(SEL_SHIFT, OP_SRA,  32'h80000001, 32'h0, 5'd4, 32'hF8000000, 0, 0, 0, 0);
        issue(SEL_SHIFT, OP_ROR,  32'h00000001, 32'h0, 5'd1, 32'h80000000, 1, 0, 0, 0);
        issue(SEL_SHIFT, OP_SLL,  32'hC0000000, 32'h0, 5'd1, 32'h80000000, 1, 0, 0, 0);
        issue(SEL_SHIFT, OP_SRL,  32'h00000003, 32'h0, 5'd1, 32'h00000001, 1, 0, 0, 0);
        issue(SEL_SHIFT, OP_ROL,  32'h80000000, 32'h0, 5'd1, 32'h00000001, 1, 0, 0, 0);
        issue(SEL_SHIFT, OP_SLL,  32'h12345678, 32'h0, 5'd0, 32'h12345678, 0, 0, 0, 0);
        // Flag set, then illegal/logic must not disturb it
        issue(SEL_ARITH, OP_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1, 0, 1, 0);
        issue(3'b111,    3'b000,  32'h12345678, 32'h1, 5'd0, 32'h0, 0, 0, 1, 1);
        issue(SEL_SHIFT, 3'b101,  32'h12345678, 32'h1, 5'd3, 32'h0, 0, 0, 1, 1);
        issue(SEL_ARITH, 3'b110,  32'h12345678, 32'h1, 5'd0, 32'h0, 0, 0, 1, 1);
        issue(SEL_LOGIC, OP_OR,   32'h00000010, 32'h00000001, 5'd0, 32'h00000011, 0, 0, 0, 0);
        issue(SEL_ARITH, OP_ADDC, 32'd0,        32'd0,        5'd0, 32'h00000001, 0, 0, 0, 0);
        idle();
        drain();

        // Backpressure: two accepts fill the pipe, outputs hold, then drain in order
        @(negedge clock);
        out_ready = 1'b0;
        issue(SEL_ARITH, OP_ADD, 32'd1,  32'd2,  5'd0, 32'h3,  0, 0, 0, 0);
        issue(SEL_LOGIC, OP_XOR, 32'hF0, 32'h0F, 5'd0, 32'hFF, 0, 0, 0, 0);
        @(negedge clock);
        aluin1    = 32'h10;
        aluin2    = 32'h01;
        opselect  = SEL_LOGIC;
        operation = OP_OR;
        #1;
        check("in_ready_full", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            check("hold_outputs", {in_ready, out_valid, aluout, carryout, zero},
                  {1'b0, 1'b1, 32'h3, 1'b0, 1'b0});
        end
        @(negedge clock);
        out_ready = 1'b1;
        #1;
        check("in_ready_release", 64'(in_ready), 64'd1);
        sb.push_back({32'h11, 1'b0, 1'b0, 1'b0, 1'b0});
        idle();
        drain();

        // Reset with two operations in flight; carry flag set beforehand
        @(negedge clock);
        out_ready = 1'b0;
        issue(SEL_ARITH, OP_ADD, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1, 0, 1, 0);
        issue(SEL_ARITH, OP_SUB, 32'd0,        32'd1, 5'd0, 32'hFFFFFFFF, 1, 0, 0, 0);
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b0;
        sb.delete();
        @(negedge clock);
        #1;
        check("flush_outputs", {out_valid, aluout, carryout, overflow, zero, illegal},
              {1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        reset     = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        #1;
        check("in_ready_after_flush", 64'(in_ready), 64'd1);
        issue(SEL_ARITH, OP_ADDC, 32'd1, 32'd1, 5'd0, 32'h2, 0, 0, 0, 0);

        // Saturating ops, or illegal encodings when the feature is absent
        issue(SEL_ARITH, OP_ADD, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1, 0, 1, 0);
`ifdef ALU_PIPE_SAT_EN
        issue(SEL_ARITH, OP_SADD, 32'h7FFFFFF0, 32'h20, 5'd0, 32'h7FFFFFFF, 0, 1, 0, 0);
        issue(SEL_ARITH, OP_SSUB, 32'h80000000, 32'h1,  5'd0, 32'h80000000, 0, 1, 0, 0);
        issue(SEL_ARITH, OP_SADD, 32'd3,        32'd4,  5'd0, 32'h7,        0, 0, 0, 0);
`else
        issue(SEL_ARITH, OP_SADD, 32'h7FFFFFF0, 32'h20, 5'd0, 32'h0, 0, 0, 1, 1);
        issue(SEL_ARITH, OP_SSUB, 32'h80000000, 32'h1,  5'd0, 32'h0, 0, 0, 1, 1);
`endif
        issue(SEL_ARITH, OP_ADDC, 32'd0, 32'd0, 5'd0, 32'h1, 0, 0, 0, 0);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined ALU that replaces the fixed 32-bit arithmetic/shift pair with a single unit. It adds logic ops, rotates, a carry-in chain and overflow/zero flags, behind a valid/ready handshake on input and output. It sits between the operand-fetch stage and writeback. It accepts one operation per cycle and returns results in issue order.

## Interface
- `WIDTH`, default 32: operand and result width; must be at least 8 and a power of two.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width; derived, not overridden.
- `clock` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clock`.
- `in_valid` input 1: the operation presented on the input ports is valid.
- `in_ready` output 1: the block accepts the operation this cycle.
- `aluin1`, `aluin2` input WIDTH: signed operands.
- `opselect` input 3: unit select; 001 = arithmetic, 010 = logic, 011 = shift; all other values are illegal.
- `operation` input 3: operation within the selected unit.
- `shift_number` input SHW: shift or rotate amount.
- `out_valid` output 1: a result is present on the output ports.
- `out_ready` input 1: the consumer takes the result this cycle.
- `aluout` output WIDTH: the result.
- `carryout` output 1: the carry, the borrow, or the last bit shifted out.
- `overflow` output 1: signed overflow; arithmetic operations only.
- `zero` output 1: `aluout` equals 0.
- `illegal` output 1: the opselect/operation encoding was not legal.

## Operation
- Arithmetic operations (opselect 001):
  - 000 ADD.
  - 001 SUB.
  - 010 ADDC: adds the internal carry flag.
  - 011 SUBB: subtracts the internal borrow flag.
- Arithmetic width rules:
  - Add and subtract are computed at WIDTH+1 bits.
  - `carryout` is the unsigned carry out of the add.
  - For SUB and SUBB, `carryout` is the borrow, set when aluin1 < aluin2 (+flag) unsigned.
  - `overflow` follows the standard signed rule.
- Logic operations (opselect 010): 000 AND, 001 OR, 010 XOR, 011 NOT aluin1. `carryout` and `overflow` are 0.
- Shift operations (opselect 011): 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; the operand is aluin1.
  - `carryout` is the last bit shifted or rotated out.
  - A shift amount of 0 gives `aluout` = aluin1 and `carryout` = 0.
- Illegal encodings: `aluout` = 0, `carryout` = 0, `overflow` = 0, `zero` = 1, `illegal` = 1. The carry flag is unchanged.
- Carry flag register:
  - Written with `carryout` each time an arithmetic operation moves from stage 1 into stage 2.
  - Unchanged by logic, shift and illegal operations.
  - ADDC and SUBB read the flag at that same transfer, so back-to-back chained operations see the flag from their predecessor.

## Timing
- Stage 1 registers the operands and opcodes. Stage 2 computes at its input and registers the result and flags.
- Latency: 2 cycles from the accept edge to `out_valid`.
- Throughput: 1 operation per cycle with no backpressure.
- Handshake:
  - Stage 2 advances when it is empty or `out_ready` is high.
  - Stage 1 advances when it is empty or stage 2 advances.
  - `in_ready` equals the stage 1 advance condition. A combinational path from `out_ready` to `in_ready` is permitted.
- Transfers: an input is accepted when `in_valid` and `in_ready` are both high; an output is taken when `out_valid` and `out_ready` are both high.
- While `out_valid` is high and `out_ready` is low, all output ports hold stable.
- At most 2 operations are in flight. When both stages are full and `out_ready` is low, `in_ready` is low.
- Reset:
  - Applies on any edge where `reset` is 0, including mid-operation.
  - Operations in flight are discarded, both stage valids clear and the carry flag clears.
  - `out_valid` = 0. `aluout`, `carryout`, `overflow` and `illegal` = 0. `zero` = 1.
  - `in_ready` is 1 from the first cycle after reset is released.

## Configuration
- Macro `ALU_PIPE_SAT_EN`.
  - When defined, arithmetic operation 100 is SADD and 101 is SSUB. Both saturate to the signed limits 0x7FFF… and 0x8000…. `overflow` reports that saturation occurred, and the carry flag is unchanged.
  - When not defined, 100 and 101 are illegal encodings.

## Structure
- Package `alu_pipe_pkg` holds:
  - the opselect and operation enumerations;
  - the `OP_*` localparams;
  - a packed struct for the stage 1 payload (operands, opcodes, shift amount).
- Sub-module `alu_pipe_shifter` is a combinational barrel shifter/rotator parametrised by WIDTH. It returns the result and the last bit out, and is instantiated once, in stage 2.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> `aluout` 0x80000000, `carryout` 0, `overflow` 1, `zero` 0, after 2 cycles.
- SUB 5 − 7 -> 0xFFFFFFFE, `carryout` 1; a following SUBB 0 − 0 -> 0xFFFFFFFF, `carryout` 1.
- SRA 0x80000001 by 4 -> 0xF8000000, `carryout` 0; ROR 0x00000001 by 1 -> 0x80000000, `carryout` 1.
- Hold `out_ready` low and issue 3 operations back to back:
  - `in_ready` falls after 2 accepts and the outputs hold;
  - raising `out_ready` drains all 3 in order with none lost.
- Drive `reset` low with 2 operations in flight -> next cycle `out_valid` 0 and the flag clears; a subsequent ADDC 1 + 1 -> 2.
- opselect 111 -> `illegal` 1, `aluout` 0, `zero` 1.
- With `ALU_PIPE_SAT_EN`, SADD 0x7FFFFFF0 + 0x20 -> 0x7FFFFFFF, `overflow` 1.
